// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 8-requester round-robin bus arbiter.
//   N_REQ            : number of requesters (matches the 8-to-1 bus mux)
//   SEL_W            : mux select width, log2(N_REQ)
//   MAX_HOLD_DEFAULT : default hold limit before preemption under contention
//   HOLD_W           : hold counter width, sized for MAX_HOLD up to 15
//   state_t          : arbiter FSM states
//   onehot()         : index -> one-hot requester vector
package bus_arb_pkg;

  localparam int N_REQ            = 8;
  localparam int SEL_W            = 3;
  localparam int MAX_HOLD_DEFAULT = 4;
  localparam int HOLD_W           = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin find-first.
// Searches req starting at index `pointer`, ascending and wrapping 7->0;
// the first set bit wins.
//   req     in  8  request vector
//   pointer in  3  index holding top priority
//   found   out 1  at least one request is set
//   idx     out 3  winning index (equals pointer when nothing is found)
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] pointer,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    found = 1'b0;
    idx   = pointer;
    cand  = pointer;
    // Walk from the farthest offset back to the nearest so the lowest
    // offset from the pointer overwrites any earlier hit. The 3-bit sum
    // wraps naturally because N_REQ is a power of two.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = pointer + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter sharing one 16-bit bus among 8 requesters.
// One idle turnaround cycle separates owners; an owner is forced off after
// MAX_HOLD cycles if anyone else is waiting.
//   clk       in  1  system clock, rising edge
//   reset     in  1  synchronous, active-high
//   req       in  8  level requests
//   done      in  8  release strobes; only the owner's bit matters
//   grant     out 8  one-hot ownership, zero when idle
//   sel       out 3  bus mux select = index of current/last owner
//   bus_valid out 1  some requester owns the bus
//   preempt   out 1  one-cycle pulse when an owner is forced off
module bus_arbiter_8
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT  // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             bus_valid,
  output logic             preempt
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    pointer_q, pointer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                bus_valid_q, bus_valid_d;
  logic                preempt_q, preempt_d;

  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic                owner_keeps;
  logic                contention;
  logic                hold_full;

  rr_pick u_rr_pick (
    .req     (req),
    .pointer (pointer_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // sel_q doubles as the owner index while OWNED.
  assign owner_keeps = req[sel_q] & ~done[sel_q];
  assign contention  = |(req & ~onehot(sel_q));
  assign hold_full   = (hold_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    hold_d      = hold_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    bus_valid_d = bus_valid_q;
    preempt_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OWNED;
          grant_d     = onehot(pick_idx);
          sel_d       = pick_idx;
          bus_valid_d = 1'b1;
          hold_d      = HOLD_W'(1);
          pointer_d   = pick_idx + SEL_W'(1);
        end
      end

      OWNED: begin
        // A voluntary release (done or dropped req) outranks preemption,
        // so a simultaneous done suppresses the preempt pulse.
        if (!owner_keeps || (hold_full && contention)) begin
          state_d     = IDLE;
          grant_d     = '0;
          bus_valid_d = 1'b0;
          hold_d      = '0;
          preempt_d   = owner_keeps;
        end else if (!hold_full) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: all of these are control registers (no storage arrays), so the
    // whole set is cleared by reset.
    if (reset) begin
      state_q     <= IDLE;
      pointer_q   <= '0;
      hold_q      <= '0;
      grant_q     <= '0;
      sel_q       <= '0;
      bus_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pointer_q   <= pointer_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      bus_valid_q <= bus_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign bus_valid = bus_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Scoreboard bench for bus_arbiter_8. Each stimulus vector is applied for
// one clock edge and the hand-computed outputs expected after that edge are
// queued; a monitor on the falling edge pops and compares them.
module tb_bus_arbiter_8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       bus_valid;
  logic       preempt;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  grant;
    logic [2:0]  sel;
    logic        bus_valid;
    logic        preempt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_id   = 0;

  bus_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id,
                       input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, want);
    end
  endtask

  // Drive one vector, let one edge happen, then queue what that edge
  // must have produced.
  task automatic apply(input logic rst_v, input logic [7:0] req_v,
                       input logic [7:0] done_v, input logic [7:0] eg,
                       input logic [2:0] es, input logic ebv, input logic epre);
    exp_t x;
    reset = rst_v;
    req   = req_v;
    done  = done_v;
    @(posedge clk);
    x.id        = 16'(vec_id);
    x.grant     = eg;
    x.sel       = es;
    x.bus_valid = ebv;
    x.preempt   = epre;
    exp_q.push_back(x);
    vec_id++;
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",     int'(e.id), grant,            e.grant);
      check("sel",       int'(e.id), {5'd0, sel},      {5'd0, e.sel});
      check("bus_valid", int'(e.id), {7'd0, bus_valid}, {7'd0, e.bus_valid});
      check("preempt",   int'(e.id), {7'd0, preempt},  {7'd0, e.preempt});
      // Structural invariant: grant agrees with sel/bus_valid.
      check("grant_vs_sel", int'(e.id), grant,
            bus_valid ? (8'h01 << sel) : 8'h00);
    end
  end

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 8'h00;

    // Reset state.
    apply(1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    apply(1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);

    // Sole requester 0 for 3 cycles, then drop.
    repeat (3) apply(0, 8'h01, 8'h00, 8'h01, 3'd0, 1, 0);
    apply(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);

    // Reset held with every request up: nothing moves.
    repeat (3) apply(1, 8'hFF, 8'h00, 8'h00, 3'd0, 0, 0);

    // Full contention: owners 0..7 then 0, 4 cycles each, then one idle
    // cycle carrying the preempt pulse and the old owner's sel.
    for (int k = 0; k < 9; k++) begin
      repeat (4) apply(0, 8'hFF, 8'h00, 8'h01 << (k % 8), 3'(k % 8), 1, 0);
      apply(0, 8'hFF, 8'h00, 8'h00, 3'(k % 8), 0, 1);
    end

    // Reset during IDLE restores pointer 0.
    apply(1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);

    // Owner 3 alone for 20+ cycles: no preemption.
    repeat (21) apply(0, 8'h08, 8'h00, 8'h08, 3'd3, 1, 0);
    // req[5] arrives: forced off next edge, then 5 wins (pointer = 4).
    apply(0, 8'h28, 8'h00, 8'h00, 3'd3, 0, 1);
    apply(0, 8'h28, 8'h00, 8'h20, 3'd5, 1, 0);
    apply(0, 8'h00, 8'h00, 8'h00, 3'd5, 0, 0);

    // Owner 2 (pointer 6 wraps to 2); done coincides with hold==4 and
    // contention from req[6]: normal release, no preempt.
    repeat (4) apply(0, 8'h04, 8'h00, 8'h04, 3'd2, 1, 0);
    apply(0, 8'h44, 8'h04, 8'h00, 3'd2, 0, 0);
    apply(0, 8'h40, 8'h00, 8'h40, 3'd6, 1, 0);
    // A non-owner done bit is ignored.
    apply(0, 8'h40, 8'h01, 8'h40, 3'd6, 1, 0);
    apply(0, 8'h00, 8'h00, 8'h00, 3'd6, 0, 0);

    // Owner 4 (pointer 7 wraps), reset mid-ownership, then req[0] wins.
    repeat (2) apply(0, 8'h10, 8'h00, 8'h10, 3'd4, 1, 0);
    apply(1, 8'h11, 8'h00, 8'h00, 3'd0, 0, 0);
    apply(0, 8'h11, 8'h00, 8'h01, 3'd0, 1, 0);
    apply(0, 8'h10, 8'h00, 8'h00, 3'd0, 0, 0);
    apply(0, 8'h10, 8'h00, 8'h10, 3'd4, 1, 0);
    apply(0, 8'h00, 8'h00, 8'h00, 3'd4, 0, 0);

    // Let the monitor drain, bounded.
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
